// File: rtl/psum_collector.sv
// Partial-sum collector: accumulates N psums per output with saturation,
// queues finished results in a FWFT FIFO and hands them out over valid/ready.
module psum_collector #(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2*BIT_WIDTH-1:0]        i_psum,
    input  logic                          i_psum_vld,
    input  logic [LEN_WIDTH-1:0]          i_len,
    input  logic                          i_clear,
    output logic [ACC_WIDTH-1:0]          o_data,
    output logic                          o_data_vld,
    input  logic                          i_data_rdy,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = ACC_WIDTH + 1;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [LEN_WIDTH-1:0]   len_q;

    logic [ACC_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic [ACC_WIDTH-1:0]   psum_ext;
    logic [SUM_W-1:0]       sum_wide;
    logic [ACC_WIDTH-1:0]   acc_sat;
    logic [LEN_WIDTH-1:0]   len_eff;
    logic                   last_beat;
    logic                   push_req;
    logic [ACC_WIDTH-1:0]   push_data;
    logic                   pop;
    logic                   full;
    logic                   push_ok;
    logic                   drop;
    logic [CNT_W-1:0]       fifo_cnt_next;
    logic                   head_from_push;

    // Saturating add and push decision for the current beat
    always_comb begin
        psum_ext  = ACC_WIDTH'(i_psum);
        sum_wide  = {1'b0, acc} + SUM_W'(i_psum);
        acc_sat   = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
        len_eff   = (i_len == '0) ? LEN_WIDTH'(1) : i_len;
        last_beat = (cnt == len_q - LEN_WIDTH'(1));
        push_req  = 1'b0;
        push_data = '0;
        if (i_psum_vld && !i_clear) begin
            if (state == IDLE && len_eff == LEN_WIDTH'(1)) begin
                push_req  = 1'b1;
                push_data = psum_ext;
            end else if (state == ACCUM && last_beat) begin
                push_req  = 1'b1;
                push_data = acc_sat;
            end
        end
    end

    // FIFO occupancy bookkeeping; a pop frees the slot a same-cycle push needs
    always_comb begin
        pop     = o_data_vld && i_data_rdy;
        full    = (o_fifo_cnt == CNT_W'(FIFO_DEPTH));
        push_ok = push_req && (!full || pop);
        drop    = push_req && full && !pop;
        fifo_cnt_next = o_fifo_cnt;
        if (push_ok && !pop) begin
            fifo_cnt_next = o_fifo_cnt + CNT_W'(1);
        end else if (!push_ok && pop) begin
            fifo_cnt_next = o_fifo_cnt - CNT_W'(1);
        end
        head_from_push = push_ok &&
                         ((o_fifo_cnt == '0) || (pop && o_fifo_cnt == CNT_W'(1)));
    end

    // Group accumulation FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            len_q  <= '0;
            o_busy <= 1'b0;
        end else if (i_clear) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            o_busy <= 1'b0;
        end else if (i_psum_vld) begin
            case (state)
                IDLE: begin
                    len_q <= len_eff;
                    acc   <= psum_ext;
                    cnt   <= LEN_WIDTH'(1);
                    if (len_eff != LEN_WIDTH'(1)) begin
                        state  <= ACCUM;
                        o_busy <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (last_beat) begin
                        state  <= IDLE;
                        acc    <= '0;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else begin
                        acc <= acc_sat;
                        cnt <= cnt + LEN_WIDTH'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Result storage; contents need no reset because occupancy gates use
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head word
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_fifo_cnt <= '0;
            o_data_vld <= 1'b0;
            o_data     <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_fifo_cnt <= fifo_cnt_next;
            o_data_vld <= (fifo_cnt_next != '0);
            if (head_from_push) begin
                o_data <= push_data;
            end else if (pop) begin
                o_data <= fifo_mem[rd_ptr + PTR_W'(1)];
            end
        end
    end

    // Sticky drop flag, cleared only by reset or i_clear
    always_ff @(posedge clk) begin
        if (rst) begin
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Consumer end of the PE partial-sum interface: takes the 2*BIT_WIDTH psum stream plus its valid strobe from the last PE of a column.
- Accumulates a configurable number of psums per output activation, with saturation at ACC_WIDTH.
- Queues finished results in a small first-word-fall-through FIFO.
- Presents queued results to the output buffer or writeback over a valid/ready handshake.

Parameters:
- BIT_WIDTH, 8, PE operand width; psum input width is 2*BIT_WIDTH.
- ACC_WIDTH, 24, accumulator and result width; must be >= 2*BIT_WIDTH.
- LEN_WIDTH, 8, width of the per-output psum-count configuration.
- FIFO_DEPTH, 8, result FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_psum  input  2*BIT_WIDTH  partial sum from PE column, unsigned
- i_psum_vld  input  1  i_psum valid, single-cycle qualifier; no backpressure toward the PE
- i_len  input  LEN_WIDTH  psums per output; sampled only on the first psum of each group
- i_clear  input  1  synchronous abort of the in-progress group; clears the overflow flag
- o_data  output  ACC_WIDTH  FIFO head result
- o_data_vld  output  1  FIFO non-empty
- i_data_rdy  input  1  consumer ready; a pop occurs when o_data_vld && i_data_rdy
- o_busy  output  1  a group is partially accumulated (state ACCUM)
- o_overflow  output  1  sticky; a result was dropped because the FIFO was full
- o_fifo_cnt  output  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values:
  - o_data = 0, o_data_vld = 0, o_busy = 0, o_overflow = 0, o_fifo_cnt = 0.
  - State IDLE; acc = 0, cnt = 0, len_q = 0.
  - FIFO pointers = 0.
- rst mid-group discards the partial accumulation and all FIFO contents.
- Arithmetic:
  - i_psum is zero-extended to ACC_WIDTH.
  - acc_next = acc + psum, computed at ACC_WIDTH+1 bits.
  - If the carry-out is set, the result saturates to all-ones (2^ACC_WIDTH - 1).
  - Once saturated, further adds stay at all-ones.
- FSM IDLE:
  - On i_psum_vld: len_q <= (i_len == 0 ? 1 : i_len), acc <= psum, cnt <= 1.
  - If the effective len is 1, push psum into the FIFO that edge and remain in IDLE.
  - Otherwise go to ACCUM.
- FSM ACCUM:
  - On i_psum_vld: cnt <= cnt + 1, acc <= acc_next.
  - When cnt == len_q - 1 (the final beat), push sat(acc + psum) into the FIFO, set acc = 0 and cnt = 0, and go to IDLE.
  - Cycles without i_psum_vld hold all state; there is no timeout.
- i_clear:
  - Sets state IDLE, acc = 0, cnt = 0, o_overflow = 0. The FIFO is untouched.
  - An i_psum_vld in the same cycle as i_clear is ignored.
- Latency: the final psum is sampled at edge N; with an empty FIFO, o_data and o_data_vld are valid after edge N (1 cycle).
- FIFO:
  - First-word-fall-through; o_data is driven from the registered head entry and holds stable while o_data_vld && !i_data_rdy.
  - o_data is don't-care when o_data_vld = 0; it is 0 after reset.
- Push and pop in the same cycle:
  - Push and pop in the same cycle leave occupancy unchanged.
  - When full, a pop in the same cycle as a push frees the slot and the push succeeds; no overflow.
  - When empty, a simultaneous push and pop is impossible because o_data_vld = 0; the pushed word appears next cycle.
- Push while full without a pop: the result is dropped, o_overflow <= 1, and occupancy stays FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH. o_fifo_cnt ranges 0..FIFO_DEPTH.
- o_busy = (state == ACCUM).

Test Plan:
1. Reset then i_len=3; psums 10, 20, 30 on consecutive cycles with rdy=1 -> one cycle after the 30 beat, o_data=60 and o_data_vld=1 for 1 cycle; o_busy high during beats 2-3 only.
2. i_len=4 with gaps (vld on cycles 0, 3, 4, 9; psums 1, 2, 3, 4) -> single result 10 after cycle 9; i_len changed to 2 mid-group has no effect.
3. ACC_WIDTH=24, i_len=255, all psums 0xFFFF -> result 0xFEFF01 (255*65535); then ACC_WIDTH=16, i_len=2, psums 0xFFFF and 0x0001 -> result 0xFFFF (saturated).
4. i_len=1, rdy=0, 9 psums 1..9 with FIFO_DEPTH=8 -> o_fifo_cnt=8, o_overflow=1, and draining yields 1..8 in order; i_clear then drops o_overflow to 0.
5. FIFO full plus a push and a pop in the same cycle -> no overflow, o_fifo_cnt stays 8, order preserved.
6. Mid-group (i_len=5, 2 beats in) assert i_clear with a coincident vld, then send 5 psums of 7 -> exactly one result 35; mid-group rst -> all outputs 0 the next cycle.
